// File: rtl/spatz_vrf_wr_arbiter.sv
// VRF write-port arbiter: per-bank arbitration of NrReq requesters with a registered bank write.
// Define SPATZ_VRF_WR_RR_EN for round-robin priority; otherwise fixed priority (index 0 highest).

module spatz_vrf_wr_bank #(
  parameter int unsigned NrReq     = 3,
  parameter int unsigned AddrWidth = 6,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned SrcW      = 2,
  parameter int unsigned BeW       = DataWidth/8
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NrReq-1:0]                    match_i,
  input  logic [NrReq-1:0][AddrWidth-1:0]     addr_i,
  input  logic [NrReq-1:0][DataWidth-1:0]     data_i,
  input  logic [NrReq-1:0][BeW-1:0]           be_i,
  output logic [NrReq-1:0]                    gnt_o,
  output logic                                wr_en_o,
  output logic [AddrWidth-1:0]                wr_addr_o,
  output logic [DataWidth-1:0]                wr_data_o,
  output logic [BeW-1:0]                      wr_be_o,
  output logic [SrcW-1:0]                     wr_src_o
);
  logic [SrcW-1:0] start, win;
  logic            any;
  int              pos;

`ifdef SPATZ_VRF_WR_RR_EN
  logic [SrcW-1:0] prio;

  // Pointer moves just past the last winner, wrapping at NrReq.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)    prio <= '0;
    else if (any) prio <= (win == SrcW'(NrReq-1)) ? '0 : win + SrcW'(1);
  end

  assign start = prio;
`else
  assign start = '0;
`endif

  always_comb begin
    any   = 1'b0;
    win   = '0;
    gnt_o = '0;
    pos   = 0;
    for (int i = 0; i < NrReq; i++) begin
      pos = int'(start) + i;
      if (pos >= NrReq) pos = pos - NrReq;
      if (!any && match_i[SrcW'(pos)]) begin
        any = 1'b1;
        win = SrcW'(pos);
      end
    end
    if (any) gnt_o[win] = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_en_o   <= 1'b0;
      wr_addr_o <= '0;
      wr_data_o <= '0;
      wr_be_o   <= '0;
      wr_src_o  <= '0;
    end else begin
      wr_en_o <= any;
      if (any) begin
        wr_addr_o <= addr_i[win];
        wr_data_o <= data_i[win];
        wr_be_o   <= be_i[win];
        wr_src_o  <= win;
      end
    end
  end
endmodule

module spatz_vrf_wr_arbiter #(
  parameter  int unsigned NrReq     = 3,
  parameter  int unsigned NrBanks   = 2,
  parameter  int unsigned AddrWidth = 6,
  parameter  int unsigned DataWidth = 64,
  localparam int unsigned BankW     = $clog2(NrBanks),
  localparam int unsigned SrcW      = $clog2(NrReq),
  localparam int unsigned BeW       = DataWidth/8
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic [NrReq-1:0]                        req_valid_i,
  output logic [NrReq-1:0]                        req_ready_o,
  input  logic [NrReq-1:0][AddrWidth+BankW-1:0]   req_addr_i,
  input  logic [NrReq-1:0][DataWidth-1:0]         req_data_i,
  input  logic [NrReq-1:0][BeW-1:0]               req_be_i,
  output logic [NrBanks-1:0]                      wr_en_o,
  output logic [NrBanks-1:0][AddrWidth-1:0]       wr_addr_o,
  output logic [NrBanks-1:0][DataWidth-1:0]       wr_data_o,
  output logic [NrBanks-1:0][BeW-1:0]             wr_be_o,
  output logic [NrBanks-1:0][SrcW-1:0]            wr_src_o
);
  logic [NrBanks-1:0][NrReq-1:0] match, gnt;
  logic [NrReq-1:0][AddrWidth-1:0] vreg;

  always_comb begin
    for (int k = 0; k < NrReq; k++) begin
      vreg[k] = req_addr_i[k][BankW +: AddrWidth];
      for (int b = 0; b < NrBanks; b++)
        match[b][k] = req_valid_i[k] && (req_addr_i[k][BankW-1:0] == BankW'(b));
    end
  end

  // Each request targets a single bank, so at most one bank can grant it.
  always_comb begin
    req_ready_o = '0;
    for (int b = 0; b < NrBanks; b++) req_ready_o = req_ready_o | gnt[b];
    if (rst_i) req_ready_o = '0;
  end

  for (genvar b = 0; b < NrBanks; b++) begin : g_bank
    spatz_vrf_wr_bank #(
      .NrReq(NrReq), .AddrWidth(AddrWidth), .DataWidth(DataWidth), .SrcW(SrcW), .BeW(BeW)
    ) i_bank (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .match_i   (match[b]),
      .addr_i    (vreg),
      .data_i    (req_data_i),
      .be_i      (req_be_i),
      .gnt_o     (gnt[b]),
      .wr_en_o   (wr_en_o[b]),
      .wr_addr_o (wr_addr_o[b]),
      .wr_data_o (wr_data_o[b]),
      .wr_be_o   (wr_be_o[b]),
      .wr_src_o  (wr_src_o[b])
    );
  end
endmodule

// File: tb/tb_spatz_vrf_wr_arbiter.sv
// Randomized bench for spatz_vrf_wr_arbiter against a queue-free per-bank priority model.
module tb_spatz_vrf_wr_arbiter;
  localparam int NR = 3, NB = 2, AW = 6, DW = 64, BW = DW/8;
`ifdef SPATZ_VRF_WR_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1;
  logic [NR-1:0]             valid, ready;
  logic [NR-1:0][AW:0]       addr;
  logic [NR-1:0][DW-1:0]     data;
  logic [NR-1:0][BW-1:0]     be;
  logic [NB-1:0]             wr_en;
  logic [NB-1:0][AW-1:0]     wr_addr;
  logic [NB-1:0][DW-1:0]     wr_data;
  logic [NB-1:0][BW-1:0]     wr_be;
  logic [NB-1:0][1:0]        wr_src;
  logic [NR-1:0]             g, r;
  int n_cmp = 0, n_err = 0;
  int prio_m[NB];
  int wait_c[NR];

  always #5 clk = ~clk;

  spatz_vrf_wr_arbiter #(.NrReq(NR), .NrBanks(NB), .AddrWidth(AW), .DataWidth(DW)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(valid), .req_ready_o(ready),
    .req_addr_i(addr), .req_data_i(data), .req_be_i(be),
    .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data), .wr_be_o(wr_be), .wr_src_o(wr_src)
  );

  // Requesters must hold a pending request unchanged until it is accepted.
  logic [NR-1:0]         pv = '0;
  logic [NR-1:0][AW:0]   pa;
  logic [NR-1:0][DW-1:0] pd;
  logic [NR-1:0][BW-1:0] pb;
  always @(posedge clk) begin
    if (!rst)
      for (int k = 0; k < NR; k++)
        if (pv[k])
          assert (valid[k] && addr[k] == pa[k] && data[k] == pd[k] && be[k] == pb[k])
            else $error("protocol violation on requester %0d", k);
    pv <= rst ? '0 : (valid & ~ready);
    pa <= addr; pd <= data; pb <= be;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ready"}, ready, 0);
    chk({tag, "_en"}, wr_en, 0);
    chk({tag, "_addr"}, wr_addr, 0);
    chk({tag, "_data0"}, wr_data[0], 0);
    chk({tag, "_data1"}, wr_data[1], 0);
    chk({tag, "_be"}, wr_be, 0);
    chk({tag, "_src"}, wr_src, 0);
  endtask

  // Called at posedge+1 with inputs driven; checks ready now and the bank writes after the edge.
  task automatic cycle(output logic [NR-1:0] gm, output logic [NR-1:0] rd);
    int w[NB];
    gm = '0;
    for (int b = 0; b < NB; b++) begin
      w[b] = -1;
      for (int off = 0; off < NR; off++) begin
        int k;
        k = (prio_m[b] + off) % NR;
        if (w[b] < 0 && valid[k] && int'(addr[k][0]) == b) w[b] = k;
      end
      if (w[b] >= 0) gm[w[b]] = 1'b1;
    end
    #2;
    rd = ready;
    chk("ready", ready, gm);
    @(posedge clk); #1;
    for (int b = 0; b < NB; b++) begin
      chk("wr_en", wr_en[b], w[b] >= 0);
      if (w[b] >= 0) begin
        chk("wr_addr", wr_addr[b], addr[w[b]][AW:1]);
        chk("wr_data", wr_data[b], data[w[b]]);
        chk("wr_be",   wr_be[b],   be[w[b]]);
        chk("wr_src",  wr_src[b],  w[b]);
        if (RR) prio_m[b] = (w[b] + 1) % NR;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    valid = '0;
    foreach (prio_m[b]) prio_m[b] = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    valid = '1;
    addr = '0; data = '0; be = '0;
    foreach (prio_m[b]) prio_m[b] = 0;
    foreach (wait_c[k]) wait_c[k] = 0;
    addr[1] = 7'h01;
    #3 chk_zero("rst_async");
    repeat (2) @(posedge clk);
    #1 chk_zero("rst_hold");
    valid = '0; rst = 1'b0;

    // Single VFU write to bank 0
    addr[0] = {6'd5, 1'b0}; data[0] = 64'hDEADBEEF_00000001; be[0] = 8'hFF; valid = 3'b001;
    cycle(g, r);
    chk("t1_rdy", r, 3'b001);
    chk("t1_addr", wr_addr[0], 6'd5);
    chk("t1_src", wr_src[0], 0);
    chk("t1_en1", wr_en[1], 0);
    do_reset();

    // Two banks in parallel
    addr[0] = {6'd3, 1'b0}; addr[1] = {6'd9, 1'b1}; valid = 3'b011;
    cycle(g, r);
    chk("t2_rdy", r, 3'b011);
    chk("t2_en", wr_en, 2'b11);
    chk("t2_src", wr_src, {2'd1, 2'd0});
    do_reset();

    // Three-way contention on bank 1
    for (int k = 0; k < NR; k++) begin
      addr[k] = {6'(10 + k), 1'b1}; data[k] = 64'(k + 100); be[k] = 8'(1 << k);
    end
    valid = 3'b111;
    for (int i = 0; i < 6; i++) begin
      cycle(g, r);
      chk("t3_seq", r, RR ? 3'(1 << (i % 3)) : 3'b001);
      chk("t3_en", wr_en[1], 1);
    end
    do_reset();

    // Pointer follows the VLSU grant, so VSLDU beats VFU next
    addr[1] = {6'd1, 1'b0}; valid = 3'b010;
    cycle(g, r);
    addr[0] = {6'd2, 1'b0}; addr[2] = {6'd4, 1'b0}; valid = 3'b101;
    cycle(g, r);
    chk("t4_win", r, RR ? 3'b100 : 3'b001);
    do_reset();

    // Reset in the cycle a write has just been registered
    addr[1] = {6'd7, 1'b0}; valid = 3'b010;
    cycle(g, r);
    addr[0] = {6'd8, 1'b0}; valid = 3'b001;
    cycle(g, r);
    rst = 1'b1;
    addr[2] = {6'd6, 1'b0}; valid = 3'b101;
    foreach (prio_m[b]) prio_m[b] = 0;
    #1 chk_zero("t5_rst");
    @(posedge clk); #1;
    chk("t5_nowr", wr_en, 0);
    rst = 1'b0;
    cycle(g, r);
    chk("t5_prio", r, 3'b001);
    do_reset();

    for (int n = 0; n < 1500; n++) begin
      for (int k = 0; k < NR; k++)
        if (!valid[k] && ($urandom % 3 != 0)) begin
          addr[k] = 7'($urandom);
          data[k] = {$urandom, $urandom};
          be[k] = 8'($urandom);
          valid[k] = 1'b1;
        end
      cycle(g, r);
      for (int k = 0; k < NR; k++) begin
        if (valid[k] && !g[k]) wait_c[k]++;
        else wait_c[k] = 0;
`ifdef SPATZ_VRF_WR_RR_EN
        if (wait_c[k] > 0) chk("fair", wait_c[k] <= NR - 1, 1);
`endif
        if (g[k]) valid[k] = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/spatz_vrf_wr_arbiter.md
# spatz_vrf_wr_arbiter

Arbitrates the three vector register file write requesters (VFU, VLSU, VSLDU, in `vreg_port_wd_e` order) onto the two VRF bank write ports. Grants at most one requester per bank per cycle with per-bank round-robin priority, then registers the winning write toward the bank. Sits between the execution units and `spatz_vrf`. Replaces the ad-hoc fixed-priority write muxing with a fair, starvation-free scheme.

## Interface
- `NrReq`, default 3: number of write requesters; index 0=VFU, 1=VLSU, 2=VSLDU.
- `NrBanks`, default 2: number of VRF banks (`NrVRFBanks`); must be a power of two.
- `AddrWidth`, default 6: per-bank word address width (`$clog2(NRVREG*NrWordsPerBank)`).
- `DataWidth`, default 64: VRF word width (`N_FU*ELEN`); byte-enable width is `DataWidth/8`.
- `clk_i` in 1: clock.
- `rst_i` in 1: asynchronous active-high reset.
- `req_valid_i` in [NrReq]: write request valid.
- `req_ready_o` out [NrReq]: request granted this cycle; the transfer completes when valid and ready are both high.
- `req_addr_i` in [NrReq][AddrWidth+$clog2(NrBanks)]: `{vreg, bank}`; the low bits select the bank.
- `req_data_i` in [NrReq][DataWidth]: write data.
- `req_be_i` in [NrReq][DataWidth/8]: byte enables.
- `wr_en_o` out [NrBanks]: bank write enable.
- `wr_addr_o` out [NrBanks][AddrWidth]: bank word address.
- `wr_data_o` out [NrBanks][DataWidth]: bank write data.
- `wr_be_o` out [NrBanks][DataWidth/8]: bank byte enables.
- `wr_src_o` out [NrBanks][$clog2(NrReq)]: index of the requester that owns the write, for scoreboard release.

## Operation
- Each request targets exactly one bank, given by its bank field. Per bank, the arbiter selects one winner among the valid requests that target that bank.
- `req_ready_o[k]` is combinational from the valid, address and priority state. It is high only for the winner of the bank it targets.
- Requests to different banks never conflict: two or more requesters may be granted in the same cycle.
- Each bank has a priority pointer `prio[b]`, width `$clog2(NrReq)`.
  - Search order starts at `prio[b]` and wraps upward modulo NrReq.
  - On a grant to requester k on bank b, `prio[b]` becomes (k+1) mod NrReq. With NrReq=3, the successor of 2 is 0.
  - With no grant on bank b, `prio[b]` holds.
- A granted write is captured into the bank's output register: en, addr (vreg field), data, be, src.
- The output register is cleared (`wr_en_o`=0) in any cycle with no grant for that bank. Addr, data, be and src may hold stale values while en=0.
- Requesters must keep valid, addr, data and be stable until ready. Dropping valid or changing the payload before the handshake is a protocol violation and is flagged by a bench assertion.
- Fairness bound: a continuously valid requester is granted within NrReq cycles.

## Timing
- Grant: 0 cycles; ready is asserted in the same cycle as valid.
- Write to bank: 1 cycle; `wr_en_o` is asserted in the cycle after the handshake.
- Throughput: one write per bank per cycle, NrBanks writes per cycle in total.
- Reset (asynchronous, immediate) drives:
  - `wr_en_o`=0, `wr_addr_o`=0, `wr_data_o`=0, `wr_be_o`=0, `wr_src_o`=0.
  - all `prio[b]`=0.
  - `req_ready_o`=0 while `rst_i` is high.
- Reset mid-operation: a write registered but not yet presented is dropped. Re-issue is owned by the requesters, which are reset together with this block.
- First cycle after reset release: priority order is 0>1>2 on every bank.

## Configuration
- Macro `SPATZ_VRF_WR_RR_EN`.
- Defined: round-robin pointers as described above.
- Undefined: fixed priority VFU > VLSU > VSLDU per bank; the `prio` registers are not instantiated and the search always starts at index 0. The fairness bound does not hold in this mode.
- Handshake, latency and reset values are identical in both modes.

## Test plan
- Reset, then VFU alone writes bank 0, addr 5, data 0xDEADBEEF_00000001, be 0xFF → ready in the same cycle; next cycle `wr_en_o[0]`=1, `wr_addr_o[0]`=5, `wr_src_o[0]`=0, `wr_en_o[1]`=0.
- VFU→bank 0 and VLSU→bank 1 in the same cycle → both ready; next cycle both banks written, `wr_src_o` = {1,0}.
- All three valid on bank 1 for 6 cycles (RR enabled) → grant sequence 0,1,2,0,1,2; `wr_en_o[1]`=1 for 6 consecutive cycles.
- Same stimulus with `SPATZ_VRF_WR_RR_EN` undefined → VFU granted every cycle, VLSU and VSLDU ready stay 0.
- VLSU granted on bank 0 → `prio[0]`=2; next cycle VFU and VSLDU both valid on bank 0 → VSLDU wins.
- `rst_i` asserted mid-stream in the cycle a write is registered → all outputs 0 immediately, no write on the following cycle, priority back to index 0.
